dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arb_select.sv | 26 ++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 64;

  // Wide enough for MEM_LAT up to 15.
  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and data-memory signals of dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 64
);
  logic              m0_req, m1_req;
  logic              m0_we, m1_we;
  logic [DATA_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
    output mem_addr, mem_wdata, mem_re, mem_we, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we, busy
  );
endinterface

// File: rtl/dmem_arb_select.sv
// Combinational tie-breaker: picks which requester is offered the grant.
// DMEM_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins) instead of round-robin.
module dmem_arb_select
  import dmem_arbiter_pkg::*;
(
  input  logic    m0_req,
  input  logic    m1_req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  req_id_t last_served,
`endif
  output req_id_t winner
);

  always_comb begin
    winner = REQ_M0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (m1_req && !m0_req) winner = REQ_M1;
`else
    if (m0_req && m1_req)
      winner = (last_served == REQ_M1) ? REQ_M0 : REQ_M1;
    else if (m1_req)
      winner = REQ_M1;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grant in IDLE, MEM_LAT-cycle ACCESS, one RESP cycle.
// Build option DMEM_ARB_FIXED_PRIO_EN replaces round-robin with fixed m0 priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 2            // legal 1..15
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q;
  req_id_t           owner_q;
  req_id_t           winner;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic              req_sel;
  logic              grant;
  logic              last_access;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  dmem_arb_select u_select (
    .m0_req (bus.m0_req),
    .m1_req (bus.m1_req),
    .winner (winner)
  );
`else
  req_id_t last_served_q;

  dmem_arb_select u_select (
    .m0_req      (bus.m0_req),
    .m1_req      (bus.m1_req),
    .last_served (last_served_q),
    .winner      (winner)
  );

  // Resets to m1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_served_q <= REQ_M1;
    else if (grant) last_served_q <= winner;
  end
`endif

  assign req_sel     = (winner == REQ_M1) ? bus.m1_req : bus.m0_req;
  assign last_access = (state_q == ACCESS) && (lat_cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst_n gating keeps gnt low while reset is held with req already high.
        if (rst_n && req_sel) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  if (lat_cnt_q == LAST_CNT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      owner_q   <= REQ_M0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q   <= winner;
        we_q      <= (winner == REQ_M1) ? bus.m1_we    : bus.m0_we;
        addr_q    <= (winner == REQ_M1) ? bus.m1_addr  : bus.m0_addr;
        wdata_q   <= (winner == REQ_M1) ? bus.m1_wdata : bus.m0_wdata;
        lat_cnt_q <= '0;
      end else if (state_q == ACCESS) begin
        lat_cnt_q <= lat_cnt_q + 1'b1;
      end
      if (last_access && !we_q) rdata_q <= bus.mem_rdata;
    end
  end

  // Latched registers only change on the grant edge, so the memory bus holds
  // its last values outside ACCESS without extra registers.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = (state_q == ACCESS) && !we_q;
  assign bus.mem_we    = (state_q == ACCESS) && we_q;

  assign bus.m0_gnt    = grant && (winner == REQ_M0);
  assign bus.m1_gnt    = grant && (winner == REQ_M1);
  assign bus.m0_rvalid = (state_q == RESP) && (owner_q == REQ_M0);
  assign bus.m1_rvalid = (state_q == RESP) && (owner_q == REQ_M1);
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 boundary instance).
module tb_dmem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    int          id;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_tests;
  int          n_fail;
  int          re_run;
  exp_t        exp_q[$];
  logic [63:0] mem_val;
  logic [63:0] exp_addr, exp_wdata, last_rd;
  logic        exp_we;

  dmem_arbiter_if #(.DATA_W(64)) bus  ();
  dmem_arbiter_if #(.DATA_W(64)) bus1 ();

  dmem_arbiter #(.DATA_W(64), .MEM_LAT(LAT)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_arbiter #(.DATA_W(64), .MEM_LAT(1))   dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: real data only in the final ACCESS cycle, junk before it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          re_run <= 0;
    else if (bus.mem_re) re_run <= re_run + 1;
    else                 re_run <= 0;
  end
  assign bus.mem_rdata  = (bus.mem_re && re_run == LAT - 1) ? mem_val : 64'hBAD0_BAD0_BAD0_BAD0;
  assign bus1.mem_rdata = 64'h0000_0000_C0DE_0001;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  task automatic monitor();
    int run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (bus.m0_gnt || bus.m1_gnt)
          chk("gnt_onehot", 64'(bus.m0_gnt & bus.m1_gnt), 64'd0);
        if (bus.m0_rvalid || bus.m1_rvalid) begin
          if (exp_q.size() == 0) begin
            chk("rvalid_unexpected", 64'({bus.m1_rvalid, bus.m0_rvalid}), 64'd0);
          end else begin
            exp_t e = exp_q.pop_front();
            chk("rv_onehot", 64'(bus.m0_rvalid & bus.m1_rvalid), 64'd0);
            chk("rv_id", 64'(bus.m1_rvalid), 64'(e.id));
            chk("rv_cycle", 64'(cyc), 64'(e.cyc));
            chk("rv_rdata", bus.rdata, e.rdata);
          end
        end
        if (bus.mem_re || bus.mem_we) begin
          run++;
          if (run == 1) begin
            chk("mem_dir", 64'({bus.mem_we, bus.mem_re}), 64'({exp_we, ~exp_we}));
            chk("mem_addr", bus.mem_addr, exp_addr);
            if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
          end
        end else if (run > 0) begin
          chk("strobe_len", 64'(run), 64'(LAT));
          run = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic r, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
    if (id == 0) begin
      bus.m0_req = r; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = r; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic note_grant(input int id, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] rdval, input int rv_cyc);
    exp_we    = we;
    exp_addr  = addr;
    exp_wdata = wdata;
    mem_val   = rdval;
    if (!we) last_rd = rdval;
    exp_q.push_back('{id, last_rd, rv_cyc});
  endtask

  // Offsets are in cycles relative to the cycle the request is raised.
  task automatic do_req(input int id, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdval,
                        input int g_off, input int rv_off);
    int base;
    bit got = 0;
    @(posedge clk); #1;
    set_req(id, 1'b1, we, addr, wdata);
    base = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.m0_gnt : bus.m1_gnt) got = 1;
    end
    chk($sformatf("gnt_seen_m%0d", id), 64'(got), 64'd1);
    if (got) begin
      chk($sformatf("gnt_cycle_m%0d", id), 64'(cyc - base), 64'(g_off));
      note_grant(id, we, addr, wdata, rdval, base + rv_off);
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          base;
    int          exp_w[4];
    logic [63:0] rdv[2];
    bit          got;
    int          w;

    n_tests = 0; n_fail = 0; cyc = 0;
    mem_val = '0; exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; last_rd = '0;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 64'h40, '0);
    set_req(1, 1'b1, 1'b1, 64'h80, 64'h1);
    bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
    bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_addr = '0; bus1.m1_wdata = '0;

    // Outputs under reset, with requests already raised.
    #3;
    chk("rst_gnt",    64'({bus.m0_gnt, bus.m1_gnt}), 64'd0);
    chk("rst_rvalid", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
    chk("rst_strobe", 64'({bus.mem_re, bus.mem_we}), 64'd0);
    chk("rst_busy",   64'(bus.busy), 64'd0);
    chk("rst_addr",   bus.mem_addr, 64'd0);
    chk("rst_wdata",  bus.mem_wdata, 64'd0);
    chk("rst_rdata",  bus.rdata, 64'd0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    fork monitor(); join_none

    // Single read: gnt at 0, mem_re 1-2, rvalid with 0xDEAD at 3.
    do_req(0, 1'b0, 64'h40, '0, 64'hDEAD, 0, 3);
    drain();

    // Tie after reset: m0 first, m1 at cycle 4; then a further tie goes to m0.
    do_reset();
    fork
      do_req(0, 1'b0, 64'h100, '0, 64'h1111, 0, 3);
      do_req(1, 1'b0, 64'h108, '0, 64'h2222, 4, 7);
    join
    fork
      do_req(0, 1'b0, 64'h110, '0, 64'h3333, 2, 5);
      do_req(1, 1'b0, 64'h118, '0, 64'h4444, 6, 9);
    join
    drain();

    // Write ack: rdata stays at the last read value 0x4444.
    do_req(1, 1'b1, 64'h80, 64'h1234, '0, 0, 3);
    drain();
    chk("wr_rdata_kept", bus.rdata, 64'h4444);

    // Both requesting continuously.
    do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_w = '{0, 0, 0, 0};
`else
    exp_w = '{0, 1, 0, 1};
`endif
    rdv = '{64'hA0A0, 64'hB1B1};
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 64'h200, '0);
    set_req(1, 1'b1, 1'b0, 64'h300, '0);
    base = cyc;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus.m0_gnt || bus.m1_gnt) got = 1;
      end
      chk("cont_gnt_seen", 64'(got), 64'd1);
      if (got) begin
        w = bus.m1_gnt ? 1 : 0;
        chk($sformatf("cont_winner_%0d", k), 64'(w), 64'(exp_w[k]));
        chk($sformatf("cont_gnt_cycle_%0d", k), 64'(cyc - base), 64'(4 * k));
        note_grant(w, 1'b0, (w == 0) ? 64'h200 : 64'h300, '0, rdv[w], base + 4 * k + 3);
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    drain();

    // Reset in cycle 1 of a read aborts it; a fresh read then completes.
    do_req(0, 1'b0, 64'h40, '0, 64'hDEAD, 0, 3);
    rst_n = 1'b0;
    exp_q.delete();
    last_rd = '0;
    #1;
    chk("abort_mem_re", 64'(bus.mem_re), 64'd0);
    chk("abort_busy",   64'(bus.busy), 64'd0);
    chk("abort_addr",   bus.mem_addr, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_rdata", bus.rdata, 64'd0);
    do_req(0, 1'b0, 64'h48, '0, 64'h5A5A, 0, 3);
    drain();

    // MEM_LAT = 1: mem_re only in cycle 1, rvalid in cycle 2.
    @(posedge clk); #1;
    bus1.m0_req = 1'b1; bus1.m0_addr = 64'h10;
    @(negedge clk);
    chk("l1_gnt", 64'(bus1.m0_gnt), 64'd1);
    @(posedge clk); #1;
    bus1.m0_req = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk($sformatf("l1_mem_re_c%0d", j), 64'(bus1.mem_re), 64'(j == 1));
      chk($sformatf("l1_rvalid_c%0d", j), 64'(bus1.m0_rvalid), 64'(j == 2));
      if (j == 2) chk("l1_rdata", bus1.rdata, 64'hC0DE_0001);
    end

    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
